// File: rtl/lvds_align_ctrl.sv
// Word-alignment sequencer for a multi-lane 7:1 LVDS receiver: bitslips each lane in turn until it shows TRAIN_PAT.
// Optional macro LVDS_ALIGN_AUTO_RETRY_EN: FAIL self-restarts after RETRY_DLY cycles instead of waiting for start.

module lvds_align_ctrl #(
  parameter int LANES = 4,
  parameter int WIDTH = 7,
  parameter logic [WIDTH-1:0] TRAIN_PAT = 7'b1100011,
  parameter int SETTLE_CYC = 4,
  parameter int MATCH_CNT = 16,
  parameter int MAX_SLIP = 7
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
  ,
  parameter int RETRY_DLY = 256
`endif
) (
  input  logic                       clkdiv,
  input  logic                       rst,
  input  logic                       locked,
  input  logic                       start,
  input  logic [LANES*WIDTH-1:0]     dat_in,
  output logic [LANES-1:0]           bitslip,
  output logic [LANES-1:0]           lane_aligned,
  output logic                       aligned,
  output logic                       busy,
  output logic                       fail,
  output logic [$clog2(LANES)-1:0]   fail_lane
);

  localparam int LW = $clog2(LANES);
  localparam int TW = $clog2(SETTLE_CYC + 1);
  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int SW = $clog2(MAX_SLIP + 2);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_CNT - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIP);
  localparam logic [LW-1:0] LANE_LAST   = LW'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOCK, CHECK, SLIP, SETTLE, DONE, FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [SW-1:0]    slip_cnt_q, slip_cnt_d;
  logic [LANES-1:0] bitslip_q, bitslip_d;
  logic [LANES-1:0] lane_aligned_q, lane_aligned_d;
  logic             aligned_q, aligned_d;
  logic             fail_q, fail_d;
  logic [LW-1:0]    fail_lane_q, fail_lane_d;
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
  localparam int RW = $clog2(RETRY_DLY + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_DLY - 1);
  logic [RW-1:0]    retry_q, retry_d;
`endif

  logic [LANES-1:0] lane_match;
  logic             cur_match;
  logic             do_restart;
  logic             do_drop;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_match[gi] = (dat_in[gi*WIDTH +: WIDTH] == TRAIN_PAT);
  end

  assign cur_match = lane_match[lane_q];

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    tmr_d          = tmr_q;
    match_cnt_d    = match_cnt_q;
    slip_cnt_d     = slip_cnt_q;
    bitslip_d      = '0;
    lane_aligned_d = lane_aligned_q;
    aligned_d      = aligned_q;
    fail_d         = fail_q;
    fail_lane_d    = fail_lane_q;
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
    retry_d        = retry_q;
`endif
    do_restart     = 1'b0;
    do_drop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) do_restart = 1'b1;
      end
      WAIT_LOCK: begin
        if (!locked) begin
          tmr_d = '0;
        end else if (tmr_q == SETTLE_LAST) begin
          state_d     = CHECK;
          tmr_d       = '0;
          lane_d      = '0;
          match_cnt_d = '0;
          slip_cnt_d  = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      CHECK: begin
        if (!locked) begin
          do_drop = 1'b1;
        end else if (cur_match) begin
          if (match_cnt_q == MATCH_LAST) begin
            lane_aligned_d[lane_q] = 1'b1;
            match_cnt_d = '0;
            slip_cnt_d  = '0;
            if (lane_q == LANE_LAST) begin
              state_d   = DONE;
              aligned_d = 1'b1;
            end else begin
              lane_d = lane_q + LW'(1);
            end
          end else begin
            match_cnt_d = match_cnt_q + MW'(1);
          end
        end else if (slip_cnt_q == SLIP_MAX) begin
          state_d     = FAIL;
          fail_d      = 1'b1;
          fail_lane_d = lane_q;
        end else begin
          // Pulse is registered, so it is high for exactly the cycle spent in SLIP.
          state_d   = SLIP;
          bitslip_d = LANES'(1) << lane_q;
        end
      end
      SLIP: begin
        if (!locked) begin
          do_drop = 1'b1;
        end else begin
          state_d    = SETTLE;
          slip_cnt_d = slip_cnt_q + SW'(1);
          tmr_d      = '0;
        end
      end
      SETTLE: begin
        if (!locked) begin
          do_drop = 1'b1;
        end else if (tmr_q == SETTLE_LAST) begin
          state_d     = CHECK;
          tmr_d       = '0;
          match_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DONE: begin
        if (start) do_restart = 1'b1;
        else if (!locked) do_drop = 1'b1;
      end
      FAIL: begin
        if (start) begin
          do_restart = 1'b1;
        end
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
        else if (retry_q == RETRY_LAST) begin
          do_restart = 1'b1;
        end else begin
          retry_d = retry_q + RW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Losing lock invalidates every lane; retraining restarts from lane 0.
    if (do_drop) begin
      state_d        = WAIT_LOCK;
      tmr_d          = '0;
      bitslip_d      = '0;
      lane_aligned_d = '0;
      aligned_d      = 1'b0;
    end

    if (do_restart) begin
      state_d        = WAIT_LOCK;
      tmr_d          = '0;
      lane_d         = '0;
      match_cnt_d    = '0;
      slip_cnt_d     = '0;
      bitslip_d      = '0;
      lane_aligned_d = '0;
      aligned_d      = 1'b0;
      fail_d         = 1'b0;
      fail_lane_d    = '0;
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
      retry_d        = '0;
`endif
    end
  end

  always_ff @(posedge clkdiv) begin
    if (rst) begin
      state_q        <= IDLE;
      lane_q         <= '0;
      tmr_q          <= '0;
      match_cnt_q    <= '0;
      slip_cnt_q     <= '0;
      bitslip_q      <= '0;
      lane_aligned_q <= '0;
      aligned_q      <= 1'b0;
      fail_q         <= 1'b0;
      fail_lane_q    <= '0;
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
      retry_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      tmr_q          <= tmr_d;
      match_cnt_q    <= match_cnt_d;
      slip_cnt_q     <= slip_cnt_d;
      bitslip_q      <= bitslip_d;
      lane_aligned_q <= lane_aligned_d;
      aligned_q      <= aligned_d;
      fail_q         <= fail_d;
      fail_lane_q    <= fail_lane_d;
`ifdef LVDS_ALIGN_AUTO_RETRY_EN
      retry_q        <= retry_d;
`endif
    end
  end

  assign bitslip      = bitslip_q;
  assign lane_aligned = lane_aligned_q;
  assign aligned      = aligned_q;
  assign fail         = fail_q;
  assign fail_lane    = fail_lane_q;
  assign busy         = (state_q == WAIT_LOCK) || (state_q == CHECK) ||
                        (state_q == SLIP) || (state_q == SETTLE);

endmodule
